// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the lfsr_gen pseudo-random source.
// Holds the run FSM encoding, default polynomial and the step function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } lfsr_fsm_e;

  localparam int         LFSR_MAX_W    = 32;
  localparam logic [7:0] LFSR_DEF_TAPS = 8'h1D;
  localparam logic [7:0] LFSR_DEF_SEED = 8'h01;

  // Inputs are zero-extended, so bits at and above w stay zero.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] s,
    input logic [LFSR_MAX_W-1:0] taps,
    input int                    w
  );
    logic [LFSR_MAX_W-1:0] r;
    logic                  fb;
    fb = ^(s & taps);
    r  = s >> 1;
    for (int i = 0; i < LFSR_MAX_W; i++) begin
      if (i == w - 1) r[i] = fb;
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR step: new bit enters at the MSB.
// Parametrised by width and feedback mask.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEF_TAPS)
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  logic [LFSR_MAX_W-1:0] w_full;

  assign w_full = lfsr_next(LFSR_MAX_W'(i_state),
                            LFSR_MAX_W'(TAPS), WIDTH);
  assign o_next = w_full[WIDTH-1:0];

  if (WIDTH < LFSR_MAX_W) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = |w_full[LFSR_MAX_W-1:WIDTH];
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with free-run, counted runs,
// period-wrap detection and zero-seed protection.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(LFSR_DEF_TAPS),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(LFSR_DEF_SEED),
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] nsteps,
  output logic [WIDTH-1:0] state,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             lockup
);

  lfsr_fsm_e        r_fsm;
  lfsr_fsm_e        w_fsm_nxt;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_ref;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed;
  logic [CNT_W-1:0] r_count;
  logic             r_wrap;
  logic             r_lockup;
  logic             w_step;
  logic             w_go;
  logic             w_zero;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .i_state (r_state),
    .o_next  (w_next)
  );

  assign w_zero = (seed == '0);
  assign w_seed = w_zero ? RESET_SEED : seed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    if (load) begin
      w_fsm_nxt = S_IDLE;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (start)
            w_fsm_nxt = (nsteps != '0) ? S_RUN : S_DONE;
        end
        S_RUN: begin
          if (r_count == CNT_W'(1)) w_fsm_nxt = S_DONE;
        end
        S_DONE:  w_fsm_nxt = S_IDLE;
        default: w_fsm_nxt = S_IDLE;
      endcase
    end
  end

  // start outranks en in IDLE; load outranks everything.
  always_comb begin
    w_go   = !load && (r_fsm == S_IDLE) && start;
    w_step = 1'b0;
    if (!load) begin
      if (r_fsm == S_RUN)
        w_step = 1'b1;
      else if (r_fsm == S_IDLE && !start && en)
        w_step = 1'b1;
    end
    busy = (r_fsm == S_RUN);
    done = (r_fsm == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RESET_SEED;
      r_ref    <= RESET_SEED;
      r_count  <= '0;
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
      if (load) begin
        r_state  <= w_seed;
        r_ref    <= w_seed;
        r_count  <= '0;
        r_lockup <= w_zero;
      end else if (w_step) begin
        r_state <= w_next;
        r_wrap  <= (w_next == r_ref);
        if (r_fsm == S_RUN) r_count <= r_count - 1'b1;
      end else if (w_go) begin
        r_count <= nsteps;
      end
    end
  end

  assign state  = r_state;
  assign wrap   = r_wrap;
  assign lockup = r_lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: directed vector table, corner sequences
// and randomized traffic against a cycle-level reference model.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] seed;
  logic       en;
  logic       start;
  logic [7:0] nsteps;
  logic [7:0] d_state;
  logic       d_busy;
  logic       d_done;
  logic       d_wrap;
  logic       d_lockup;

  always #5 clk = ~clk;

  lfsr_gen dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .seed   (seed),
    .en     (en),
    .start  (start),
    .nsteps (nsteps),
    .state  (d_state),
    .busy   (d_busy),
    .done   (d_done),
    .wrap   (d_wrap),
    .lockup (d_lockup)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: remaining run steps and a pending done flag.
  logic [7:0] m_state;
  logic [7:0] m_ref;
  int         m_left;
  bit         m_done;
  bit         m_wrap;
  bit         m_lock;

  typedef struct {
    bit         ld;
    logic [7:0] sd;
    bit         e;
    bit         st;
    logic [7:0] n;
    logic [7:0] xs;
    bit         xb;
    bit         xd;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [7:0] ref_step(logic [7:0] s);
    int fb;
    fb = $countones(s & 8'h1D) % 2;
    return (s >> 1) + 8'(fb * 128);
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 8'h01;
    m_ref   = 8'h01;
    m_left  = 0;
    m_done  = 0;
    m_wrap  = 0;
    m_lock  = 0;
  endtask

  task automatic model_tick(bit ld, logic [7:0] sd, bit e,
                            bit st, logic [7:0] n);
    m_wrap = 0;
    m_lock = 0;
    if (ld) begin
      m_state = (sd == 0) ? 8'h01 : sd;
      m_ref   = m_state;
      m_lock  = (sd == 0);
      m_left  = 0;
      m_done  = 0;
    end else if (m_left > 0) begin
      m_state = ref_step(m_state);
      m_wrap  = (m_state == m_ref);
      m_left--;
      m_done  = (m_left == 0);
    end else if (m_done) begin
      m_done = 0;
    end else if (st) begin
      if (n != 0) m_left = int'(n);
      else        m_done = 1;
    end else if (e) begin
      m_state = ref_step(m_state);
      m_wrap  = (m_state == m_ref);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".state"},  d_state,  m_state);
    chk({tag, ".busy"},   d_busy,   m_left > 0);
    chk({tag, ".done"},   d_done,   m_done);
    chk({tag, ".wrap"},   d_wrap,   m_wrap);
    chk({tag, ".lockup"}, d_lockup, m_lock);
  endtask

  task automatic cyc(string tag, bit ld, logic [7:0] sd,
                     bit e, bit st, logic [7:0] n);
    load   = ld;
    seed   = sd;
    en     = e;
    start  = st;
    nsteps = n;
    @(posedge clk);
    model_tick(ld, sd, e, st, n);
    #1;
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         wraps;
    int         wstep;
    int         dups;
    int         zeros;
    int         bcnt;
    bit         seen[256];
    bit         got_done;
    logic [7:0] rs;

    tbl[0]  = '{1, 8'h01, 0, 0, 8'd0, 8'h01, 0, 0};
    tbl[1]  = '{0, 8'h00, 1, 0, 8'd0, 8'h80, 0, 0};
    tbl[2]  = '{0, 8'h00, 1, 0, 8'd0, 8'h40, 0, 0};
    tbl[3]  = '{0, 8'h00, 1, 0, 8'd0, 8'h20, 0, 0};
    tbl[4]  = '{0, 8'h00, 1, 0, 8'd0, 8'h10, 0, 0};
    tbl[5]  = '{0, 8'h00, 1, 0, 8'd0, 8'h88, 0, 0};
    tbl[6]  = '{1, 8'h01, 0, 0, 8'd0, 8'h01, 0, 0};
    tbl[7]  = '{0, 8'h00, 0, 1, 8'd4, 8'h01, 1, 0};
    tbl[8]  = '{0, 8'h00, 1, 1, 8'd4, 8'h80, 1, 0};
    tbl[9]  = '{0, 8'h00, 0, 0, 8'd0, 8'h40, 1, 0};
    tbl[10] = '{0, 8'h00, 0, 0, 8'd0, 8'h20, 1, 0};
    tbl[11] = '{0, 8'h00, 0, 0, 8'd0, 8'h10, 0, 1};
    tbl[12] = '{0, 8'h00, 0, 1, 8'd4, 8'h10, 0, 0};
    tbl[13] = '{0, 8'h00, 0, 0, 8'd0, 8'h10, 0, 0};
    tbl[14] = '{0, 8'h00, 0, 1, 8'd0, 8'h10, 0, 1};
    tbl[15] = '{0, 8'h00, 1, 0, 8'd0, 8'h10, 0, 0};

    rst = 1'b1;
    load = 0; seed = 0; en = 0; start = 0; nsteps = 0;
    model_reset();
    #12;
    check_all("reset");
    #5 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      cyc("tbl", tbl[i].ld, tbl[i].sd, tbl[i].e,
          tbl[i].st, tbl[i].n);
      chk($sformatf("tbl%0d.state", i), d_state, tbl[i].xs);
      chk($sformatf("tbl%0d.busy", i),  d_busy,  tbl[i].xb);
      chk($sformatf("tbl%0d.done", i),  d_done,  tbl[i].xd);
    end

    // Asynchronous reset in the middle of a run.
    cyc("mr", 0, 0, 0, 1, 8'd8);
    cyc("mr", 0, 0, 0, 0, 8'd0);
    cyc("mr", 0, 0, 0, 0, 8'd0);
    load = 0; en = 0; start = 0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    #2 rst = 1'b0;
    cyc("post_rst", 0, 0, 0, 0, 8'd0);
    chk("post_rst.nodone", d_done, 0);

    // Full period with wrap detection.
    cyc("per", 1, 8'h01, 0, 0, 8'd0);
    foreach (seen[k]) seen[k] = 0;
    seen[1] = 1;
    wraps = 0; wstep = 0; dups = 0;
    for (int i = 1; i <= 255; i++) begin
      cyc("per", 0, 0, 1, 0, 8'd0);
      if (d_wrap) begin wraps++; wstep = i; end
      if (i < 255) begin
        if (seen[d_state]) dups++;
        seen[d_state] = 1;
      end
    end
    chk("per.wraps", wraps, 1);
    chk("per.wstep", wstep, 255);
    chk("per.state", d_state, 8'h01);
    chk("per.dups", dups, 0);
    cyc("n0", 0, 0, 0, 1, 8'd0);
    chk("n0.done", d_done, 1);
    chk("n0.state", d_state, 8'h01);

    // Zero seed substitution.
    cyc("zs", 1, 8'h00, 0, 0, 8'd0);
    chk("zs.state", d_state, 8'h01);
    chk("zs.lock", d_lockup, 1);
    cyc("zs1", 0, 0, 1, 0, 8'd0);
    chk("zs1.lock", d_lockup, 0);
    zeros = 0;
    for (int i = 0; i < 40; i++) begin
      cyc("zsr", 0, 0, 1, 0, 8'd0);
      if (d_state == 0) zeros++;
    end
    chk("zs.zeros", zeros, 0);

    // Abort a run with a load at step 3.
    cyc("ab", 0, 0, 0, 1, 8'd10);
    for (int i = 0; i < 3; i++)
      cyc("ab", 0, 0, 0, 0, 8'd0);
    cyc("ab.ld", 1, 8'hA5, 0, 0, 8'd0);
    chk("ab.state", d_state, 8'hA5);
    chk("ab.busy", d_busy, 0);
    got_done = 0;
    for (int i = 0; i < 12; i++) begin
      cyc("ab.idle", 0, 0, 0, 0, 8'd0);
      if (d_done) got_done = 1;
    end
    chk("ab.nodone", got_done, 0);
    cyc("ab2", 0, 0, 0, 1, 8'd10);
    rs = 8'hA5;
    for (int i = 0; i < 10; i++) rs = ref_step(rs);
    bcnt = 0;
    got_done = 0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (d_busy) bcnt++;
      cyc("ab2", 0, 0, 0, 0, 8'd0);
      got_done = d_done;
    end
    chk("ab2.done", got_done, 1);
    chk("ab2.busy_cycles", bcnt, 10);
    chk("ab2.state", d_state, rs);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit         rl;
      logic [7:0] rsd;
      rl  = ($urandom_range(0, 31) == 0);
      rsd = ($urandom_range(0, 3) == 0) ? 8'h00
                                       : 8'($urandom);
      cyc("rnd", rl, rsd, 1'($urandom),
          ($urandom_range(0, 7) == 0),
          8'($urandom_range(0, 12)));
      chk("rnd.nonzero", d_state != 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
